imem_loader: RTL

Program loader for the single-cycle MIPS core: the write-side counterpart of the instruction fetch path. It receives a framed byte stream over a valid/ready handshake and writes it into the instruction memory byte storage. It verifies an XOR checksum and holds the CPU in reset until a load completes successfully. It sits between the host/bench byte source and the byte write port of the IFU instruction memory, and replaces file-based preloading in system-level runs.

---
 rtl/imem_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader into instruction memory with XOR check
module imem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]            mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   // Bytes available from BASE_ADDR to the top of memory; 19 bits so 2^ADDR_WIDTH itself fits.
   localparam logic [18:0]           CAPACITY = 19'((1 << ADDR_WIDTH) - BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

   state_t              state;
   logic [7:0]          len_hi;
   logic [7:0]          xacc;
   logic [17:0]         total;
   logic [ADDR_WIDTH:0] cnt;
   logic                fire;
   logic [17:0]         len_bytes;
   logic [17:0]         cnt_next;

   // Ready is a pure decode of state, never of in_valid.
   assign in_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
   assign cpu_hold  = (state != S_DONE);
   assign fire      = in_valid && in_ready;
   // 4*N in 18 bits so no word count can wrap the size check.
   assign len_bytes = {len_hi, in_data, 2'b00};
   assign cnt_next  = 18'(cnt) + 18'd1;

   // Frame FSM: length parse, payload writes with running XOR, checksum verdict.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         len_hi    <= '0;
         xacc      <= '0;
         total     <= '0;
         cnt       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= BASE;
         mem_wdata <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state <= S_LEN_HI;
                  cnt   <= '0;
                  xacc  <= '0;
                  done  <= 1'b0;
                  error <= 1'b0;
               end
            end
            S_LEN_HI: begin
               if (fire) begin
                  len_hi <= in_data;
                  state  <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (fire) begin
                  total <= len_bytes;
                  if ({1'b0, len_bytes} > CAPACITY) begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end else if (len_bytes == '0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (fire) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= BASE + cnt[ADDR_WIDTH-1:0];
                  mem_wdata <= in_data;
                  xacc      <= xacc ^ in_data;
                  cnt       <= cnt + CNT_ONE;
                  if (cnt_next == total) begin
                     state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (fire) begin
                  if (in_data == xacc) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
